// File: rtl/booth_mult_pkg.sv
// Shared types and constants for the sequential radix-2 Booth multiplier.
package booth_mult_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Booth pair {P[1], P[0]} encodings
   localparam logic [1:0] PAIR_NOP0 = 2'b00;
   localparam logic [1:0] PAIR_NOP1 = 2'b11;
   localparam logic [1:0] PAIR_ADD  = 2'b01;
   localparam logic [1:0] PAIR_SUB  = 2'b10;

   function automatic int cnt_width(input int width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/booth_mult_seq_step.sv
// One combinational radix-2 Booth step: conditional add/sub on the upper
// field of P followed by a one-bit arithmetic shift right of all of P.
module booth_step
   import booth_mult_pkg::*;
#(
   parameter int E = 33
) (
   input  logic [2*E:0] p_i,
   input  logic [E-1:0] mcand_i,
   output logic [2*E:0] p_o
);

   logic [E-1:0] upper;

   always_comb begin
      upper = p_i[2*E:E+1];
      case (p_i[1:0])
         PAIR_ADD: upper = p_i[2*E:E+1] + mcand_i;
         PAIR_SUB: upper = p_i[2*E:E+1] - mcand_i;
         default:  upper = p_i[2*E:E+1];
      endcase
      p_o = {upper[E-1], upper, p_i[E:1]};
   end

endmodule

// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier, signed/unsigned per operation.
// Optional overflow flag output enabled by defining BOOTH_MULT_OVF_EN.
//
// state | meaning
// IDLE  | waiting for start; operands latched on accept
// RUN   | one Booth step per clock, E = WIDTH+1 steps
// DONE  | publish hi/lo, pulse done, return to IDLE
module booth_mult_seq
   import booth_mult_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             done
`ifdef BOOTH_MULT_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int E  = WIDTH + 1;
   localparam int PW = 2 * E + 1;
   localparam int CW = cnt_width(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(E - 1);

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [PW-1:0]    p_q, p_d;
   logic [E-1:0]     mcand_q, mcand_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [PW-1:0]    p_step;
   logic [WIDTH-1:0] prod_hi, prod_lo;
   logic [E-1:0]     a_ext, b_ext;

   // Extending to W+1 bits lets the same signed engine handle unsigned operands
   assign a_ext   = {is_signed & a[WIDTH-1], a};
   assign b_ext   = {is_signed & b[WIDTH-1], b};
   assign prod_hi = p_q[2*WIDTH:WIDTH+1];
   assign prod_lo = p_q[WIDTH:1];

   booth_step #(.E(E)) u_step (
      .p_i     (p_q),
      .mcand_i (mcand_q),
      .p_o     (p_step)
   );

`ifdef BOOTH_MULT_OVF_EN
   logic sgn_q, sgn_d;
   logic ovf_q, ovf_d;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      p_d     = p_q;
      mcand_d = mcand_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
`ifdef BOOTH_MULT_OVF_EN
      sgn_d   = sgn_q;
      ovf_d   = ovf_q;
`endif
      case (state_q)
         IDLE: begin
            busy_d = 1'b0;
            if (start) begin
               mcand_d = a_ext;
               p_d     = {{E{1'b0}}, b_ext, 1'b0};
               cnt_d   = '0;
               busy_d  = 1'b1;
               state_d = RUN;
`ifdef BOOTH_MULT_OVF_EN
               sgn_d   = is_signed;
`endif
            end
         end
         RUN: begin
            p_d   = p_step;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == LAST) begin
               state_d = DONE;
            end
         end
         DONE: begin
            hi_d    = prod_hi;
            lo_d    = prod_lo;
            done_d  = 1'b1;
            state_d = IDLE;
`ifdef BOOTH_MULT_OVF_EN
            ovf_d   = sgn_q ? (prod_hi != {WIDTH{prod_lo[WIDTH-1]}})
                            : (prod_hi != '0);
`endif
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         p_q     <= '0;
         mcand_q <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         p_q     <= p_d;
         mcand_q <= mcand_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

`ifdef BOOTH_MULT_OVF_EN
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sgn_q <= 1'b0;
         ovf_q <= 1'b0;
      end else begin
         sgn_q <= sgn_d;
         ovf_q <= ovf_d;
      end
   end

   assign ovf = ovf_q;
`endif

   assign hi   = hi_q;
   assign lo   = lo_q;
   assign busy = busy_q;
   assign done = done_q;

endmodule

// File: tb/tb_booth_mult_seq.sv
// Directed bench for booth_mult_seq at WIDTH=32 and WIDTH=8; expected
// products are hand-computed. Checks ovf as well when BOOTH_MULT_OVF_EN is set.
module tb_booth_mult_seq;

   logic        clk = 1'b0;
   logic        rst = 1'b1;

   logic        start32 = 1'b0, sg32 = 1'b0;
   logic [31:0] a32 = '0, b32 = '0;
   logic [31:0] hi32, lo32;
   logic        busy32, done32;

   logic        start8 = 1'b0, sg8 = 1'b0;
   logic [7:0]  a8 = '0, b8 = '0;
   logic [7:0]  hi8, lo8;
   logic        busy8, done8;

`ifdef BOOTH_MULT_OVF_EN
   logic ovf32, ovf8;
`endif

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   booth_mult_seq #(.WIDTH(32)) dut32 (
      .clock     (clk),
      .reset     (rst),
      .start     (start32),
      .is_signed (sg32),
      .a         (a32),
      .b         (b32),
      .hi        (hi32),
      .lo        (lo32),
      .busy      (busy32),
      .done      (done32)
`ifdef BOOTH_MULT_OVF_EN
      ,
      .ovf       (ovf32)
`endif
   );

   booth_mult_seq #(.WIDTH(8)) dut8 (
      .clock     (clk),
      .reset     (rst),
      .start     (start8),
      .is_signed (sg8),
      .a         (a8),
      .b         (b8),
      .hi        (hi8),
      .lo        (lo8),
      .busy      (busy8),
      .done      (done8)
`ifdef BOOTH_MULT_OVF_EN
      ,
      .ovf       (ovf8)
`endif
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Launch one 32-bit op, scramble inputs after the start edge, wait for done.
   task automatic op32(input logic sg, input logic [31:0] av, input logic [31:0] bv,
                       input logic [31:0] prev_hi, output int lat);
      @(negedge clk);
      start32 = 1'b1; sg32 = sg; a32 = av; b32 = bv;
      @(posedge clk);
      @(negedge clk);
      start32 = 1'b0; sg32 = ~sg; a32 = $urandom; b32 = $urandom;
      check("busy_on_start", busy32, 1'b1);
      check("hi_held", hi32, prev_hi);
      lat = 0;
      while (lat < 60) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         if (done32) break;
      end
   endtask

   task automatic pulse_end32();
      @(posedge clk);
      @(negedge clk);
      check("done_drop", done32, 1'b0);
      check("busy_drop", busy32, 1'b0);
   endtask

   initial begin
      int lat, n, nd, d1, d2;

      repeat (2) @(negedge clk);
      check("rst_hi", hi32, 0);
      check("rst_lo", lo32, 0);
      check("rst_busy", busy32, 0);
      check("rst_done", done32, 0);
`ifdef BOOTH_MULT_OVF_EN
      check("rst_ovf", ovf32, 0);
`endif
      rst = 1'b0;

      // 5 * -3 signed
      op32(1'b1, 32'd5, 32'hFFFF_FFFD, 32'h0, lat);
      check("s5xm3_lat", lat, 34);
      check("s5xm3_hi", hi32, 32'hFFFF_FFFF);
      check("s5xm3_lo", lo32, 32'hFFFF_FFF1);
      pulse_end32();

      // 0xFFFFFFFF squared unsigned
      op32(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
      check("umax_lat", lat, 34);
      check("umax_hi", hi32, 32'hFFFF_FFFE);
      check("umax_lo", lo32, 32'h0000_0001);
`ifdef BOOTH_MULT_OVF_EN
      check("umax_ovf", ovf32, 1'b1);
`endif
      pulse_end32();

      // -1 * -1 signed
      op32(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, lat);
      check("sm1_lat", lat, 34);
      check("sm1_hi", hi32, 32'h0);
      check("sm1_lo", lo32, 32'h1);
`ifdef BOOTH_MULT_OVF_EN
      check("sm1_ovf", ovf32, 1'b0);
`endif
      pulse_end32();

      // signed min * min, with an ignored start pulsed mid-RUN
      @(negedge clk);
      start32 = 1'b1; sg32 = 1'b1; a32 = 32'h8000_0000; b32 = 32'h8000_0000;
      @(posedge clk);
      @(negedge clk);
      start32 = 1'b0; sg32 = 1'b0; a32 = 32'd3; b32 = 32'd4;
      n = 0; nd = 0; d1 = 0;
      while (n < 60) begin
         @(posedge clk);
         n++;
         @(negedge clk);
         start32 = (n == 10);
         if (done32) begin
            nd++;
            if (nd == 1) begin
               d1 = n;
               check("smin_hi", hi32, 32'h4000_0000);
               check("smin_lo", lo32, 32'h0);
`ifdef BOOTH_MULT_OVF_EN
               check("smin_ovf", ovf32, 1'b1);
`endif
            end
         end
      end
      start32 = 1'b0;
      check("ign_done_count", nd, 1);
      check("ign_lat", d1, 34);
      check("ign_hi_final", hi32, 32'h4000_0000);

      // asynchronous reset 10 cycles into RUN
      @(negedge clk);
      start32 = 1'b1; sg32 = 1'b1; a32 = 32'd5; b32 = 32'hFFFF_FFFD;
      @(posedge clk);
      @(negedge clk);
      start32 = 1'b0;
      repeat (10) @(posedge clk);
      #3 rst = 1'b1;
      #1;
      check("arst_hi", hi32, 0);
      check("arst_lo", lo32, 0);
      check("arst_busy", busy32, 0);
      check("arst_done", done32, 0);
      @(negedge clk);
      rst = 1'b0;

      // fresh op after reset: -7 * 6 signed
      op32(1'b1, 32'hFFFF_FFF9, 32'd6, 32'h0, lat);
      check("post_lat", lat, 34);
      check("post_hi", hi32, 32'hFFFF_FFFF);
      check("post_lo", lo32, 32'hFFFF_FFD6);
      pulse_end32();

      // WIDTH=8: 0x7F * 0x81 signed, start held high
      @(negedge clk);
      start8 = 1'b1; sg8 = 1'b1; a8 = 8'h7F; b8 = 8'h81;
      @(posedge clk);
      n = 0; nd = 0; d1 = 0; d2 = 0;
      while (n < 40 && nd < 2) begin
         @(posedge clk);
         n++;
         @(negedge clk);
         if (done8) begin
            nd++;
            if (nd == 1) d1 = n;
            else d2 = n;
            check("w8_hi", hi8, 8'hC0);
            check("w8_lo", lo8, 8'hFF);
`ifdef BOOTH_MULT_OVF_EN
            check("w8_ovf", ovf8, 1'b1);
`endif
         end
      end
      start8 = 1'b0;
      check("w8_first_lat", d1, 10);
      check("w8_second_lat", d2, 21);
      repeat (15) @(negedge clk);
      check("w8_idle_busy", busy8, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
